// File: rtl/game_pkg.sv
// Shared game constants: sprite geometry, spawn offset, dino band, LFSR seed/taps.
// Used by obstacle_field and cactus_rom.
package game_pkg;

  localparam int SMALL_W    = 12;
  localparam int SMALL_H    = 24;
  localparam int LARGE_W    = 20;
  localparam int LARGE_H    = 40;
  localparam int GROUND_TOP = 400;
  localparam int SPAWN_OFS  = 32;
  localparam int DINO_L     = 40;
  localparam int DINO_R     = 79;

  // Dino band expressed in slot-position units (screen column + SPAWN_OFS)
  localparam logic [10:0] DINO_LO_X = 11'(DINO_L + SPAWN_OFS);
  localparam logic [10:0] DINO_HI_X = 11'(DINO_R + SPAWN_OFS);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as zero-based bit indices
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic        act;
    logic [10:0] pos;
    logic        typ;
  } slot_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  function automatic logic [10:0] spr_w(input logic typ);
    return typ ? 11'(LARGE_W) : 11'(SMALL_W);
  endfunction

  function automatic logic [8:0] spr_top(input logic typ);
    return typ ? 9'(GROUND_TOP - LARGE_H) : 9'(GROUND_TOP - SMALL_H);
  endfunction

endpackage

// File: rtl/cactus_rom.sv
// Combinational cactus bitmaps; bit c of bits_o is sprite column c (leftmost = bit 0).
// Large rows only exist when OBSTACLE_LARGE_EN is defined.
module cactus_rom
  import game_pkg::*;
(
  input  logic        typ_i,
  input  logic [5:0]  row_i,
  output logic [19:0] bits_o
);

  localparam logic [19:0] S_TOP   = 20'h00060;
  localparam logic [19:0] S_TRUNK = 20'h000F0;
  localparam logic [19:0] S_ARMS  = 20'h00C03;
  localparam logic [19:0] S_JOIN  = 20'h00FFF;
`ifdef OBSTACLE_LARGE_EN
  localparam logic [19:0] L_TOP   = 20'h00F00;
  localparam logic [19:0] L_TRUNK = 20'h01F80;
  localparam logic [19:0] L_ARMS  = 20'hE0007;
  localparam logic [19:0] L_JOIN  = 20'hFFFFF;
`endif

  always_comb begin
    bits_o = '0;
    if (!typ_i) begin
      if (row_i == 6'd0)                bits_o = S_TOP;
      else if (row_i < 6'd6)            bits_o = S_TRUNK;
      else if (row_i < 6'd12)           bits_o = S_TRUNK | S_ARMS;
      else if (row_i < 6'd14)           bits_o = S_JOIN;
      else if (row_i < 6'(SMALL_H))     bits_o = S_TRUNK;
    end
`ifdef OBSTACLE_LARGE_EN
    else begin
      if (row_i == 6'd0)                bits_o = L_TOP;
      else if (row_i < 6'd10)           bits_o = L_TRUNK;
      else if (row_i < 6'd20)           bits_o = L_TRUNK | L_ARMS;
      else if (row_i < 6'd23)           bits_o = L_JOIN;
      else if (row_i < 6'(LARGE_H))     bits_o = L_TRUNK;
    end
`endif
  end

endmodule

// File: rtl/obstacle_field.sv
// Two-slot scrolling cactus field: spawn/retire on frame ticks, registered pixel and
// dino-proximity outputs. Define OBSTACLE_LARGE_EN to allow large cacti.
module obstacle_field
  import game_pkg::*;
#(
  parameter logic [10:0] SPAWN_X = 11'd672,
  parameter logic [5:0]  GAP_MIN = 6'd24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fresh,
  input  logic       game_status,
  input  logic [3:0] speed,
  input  logic [8:0] row_addr,
  input  logic [9:0] col_addr,
  output logic       px,
  output logic       obs_near
);

  localparam int NSLOT = 2;

  state_e                state_q, state_d;
  logic                  fresh_q, gs_q;
  logic [15:0]           lfsr_q;
  slot_t [NSLOT-1:0]     slot_q, slot_d;
  logic [5:0]            gap_cnt_q, gap_cnt_d, gap_tgt_q, gap_tgt_d;
  logic                  px_q, px_d, near_q, near_d;

  logic                  tick, gs_rise, gs_fall, free_pre, spawn_idx, spawn_typ, near_any;
  logic [5:0]            gap_inc;
  logic [10:0]           spd11, x_pos;
  logic [NSLOT-1:0]      hit;

  assign tick    = fresh_q & ~fresh;
  assign gs_rise = game_status & ~gs_q;
  assign gs_fall = ~game_status & gs_q;
  assign spd11   = {7'd0, speed};

`ifdef OBSTACLE_LARGE_EN
  assign spawn_typ = lfsr_q[5];
`else
  assign spawn_typ = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    gap_cnt_d = gap_cnt_q;
    gap_tgt_d = gap_tgt_q;
    near_d    = near_q;
    near_any  = 1'b0;
    // Spawn eligibility uses occupancy before this tick's retires
    free_pre  = ~slot_q[0].act | ~slot_q[1].act;
    spawn_idx = slot_q[0].act;
    gap_inc   = (gap_cnt_q < gap_tgt_q) ? gap_cnt_q + 6'd1 : gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (gs_rise) begin
          state_d   = ST_RUN;
          slot_d    = '0;
          gap_cnt_d = '0;
          gap_tgt_d = GAP_MIN + 6'd16;
        end
      end
      ST_RUN: begin
        if (gs_fall) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (slot_q[i].act) begin
              if (slot_q[i].pos <= spd11) slot_d[i].act = 1'b0;
              else                        slot_d[i].pos = slot_q[i].pos - spd11;
            end
          end
          if (gap_inc == gap_tgt_q && free_pre) begin
            slot_d[spawn_idx].act = 1'b1;
            slot_d[spawn_idx].pos = SPAWN_X;
            slot_d[spawn_idx].typ = spawn_typ;
            gap_cnt_d             = '0;
            gap_tgt_d             = GAP_MIN + {1'b0, lfsr_q[4:0]};
          end else begin
            gap_cnt_d = gap_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NSLOT; i++) begin
      if (slot_d[i].act && slot_d[i].pos <= DINO_HI_X &&
          (slot_d[i].pos + spr_w(slot_d[i].typ) - 11'd1) >= DINO_LO_X)
        near_any = 1'b1;
    end
    if (tick) near_d = near_any;
  end

  // Pixel x in slot-position units so the box test never goes below zero
  assign x_pos = {1'b0, col_addr} + 11'(SPAWN_OFS);

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic [10:0] dx, w;
    logic [8:0]  top;
    logic [5:0]  ry;
    logic [19:0] bits;
    logic        in_col, in_row;

    assign w      = spr_w(slot_q[i].typ);
    assign top    = spr_top(slot_q[i].typ);
    assign dx     = x_pos - slot_q[i].pos;
    assign in_col = (x_pos >= slot_q[i].pos) && (dx < w);
    assign in_row = (row_addr >= top) && (row_addr < 9'(GROUND_TOP));
    assign ry     = 6'(row_addr - top);

    cactus_rom u_rom (
      .typ_i  (slot_q[i].typ),
      .row_i  (ry),
      .bits_o (bits)
    );

    assign hit[i] = slot_q[i].act & in_col & in_row & bits[dx[4:0]];
  end

  assign px_d = |hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fresh_q   <= 1'b0;
      gs_q      <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      slot_q    <= '0;
      gap_cnt_q <= '0;
      gap_tgt_q <= GAP_MIN + 6'd16;
      px_q      <= 1'b0;
      near_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fresh_q   <= fresh;
      gs_q      <= game_status;
      lfsr_q    <= lfsr_step(lfsr_q);
      slot_q    <= slot_d;
      gap_cnt_q <= gap_cnt_d;
      gap_tgt_q <= gap_tgt_d;
      px_q      <= px_d;
      near_q    <= near_d;
    end
  end

  assign px       = px_q;
  assign obs_near = near_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field with a tick-level slot model and a px scoreboard.
`timescale 1ns/1ps
module tb_obstacle_field;

  logic       clk = 1'b0;
  logic       rst, fresh, game_status;
  logic [3:0] speed;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       px, obs_near;

  obstacle_field dut (
    .clk(clk), .rst(rst), .fresh(fresh), .game_status(game_status), .speed(speed),
    .row_addr(row_addr), .col_addr(col_addr), .px(px), .obs_near(obs_near)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic exp; string tag; } sb_t;
  sb_t sbq[$];

  logic [15:0] lf_m;
  always @(posedge clk)
    lf_m <= rst ? 16'hACE1 : {lf_m[14:0], lf_m[15] ^ lf_m[13] ^ lf_m[12] ^ lf_m[10]};

  bit m_run;
  bit m_act[2];
  int m_pos[2];
  int m_gc, m_gt, spawns;
  bit m_near;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_done(string tag, bit reached);
    checks++;
    assert (reached) else begin
      failures++;
      $error("FAIL %s: observed not reached, expected reached within bound", tag);
    end
  endtask

  function automatic logic small_bit(int r, int c);
    if (c < 0 || c > 11 || r < 0 || r > 23) return 1'b0;
    if (r == 0) return (c == 5 || c == 6);
    if (r >= 12 && r <= 13) return 1'b1;
    if (c >= 4 && c <= 7) return 1'b1;
    if (r >= 6 && r <= 11 && (c <= 1 || c >= 10)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pop_cmp();
    sb_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk(e.tag, px, e.exp);
    end
  endtask

  // Address changes every cycle, so each compare also pins the 1-clk latency
  task automatic probe(int r, int c, logic e, string tag);
    sb_t s;
    @(negedge clk);
    pop_cmp();
    row_addr = 9'(r);
    col_addr = 10'(c);
    s.exp = e;
    s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic flush();
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic model_tick(logic [15:0] lf);
    bit free_pre;
    int idx, gi;
    if (m_run) begin
      free_pre = !m_act[0] || !m_act[1];
      idx = m_act[0] ? 1 : 0;
      for (int i = 0; i < 2; i++)
        if (m_act[i]) begin
          if (m_pos[i] <= int'(speed)) m_act[i] = 0;
          else m_pos[i] = m_pos[i] - int'(speed);
        end
      gi = (m_gc < m_gt) ? m_gc + 1 : m_gc;
      if (gi == m_gt && free_pre) begin
        m_act[idx] = 1;
        m_pos[idx] = 672;
        m_gc = 0;
        m_gt = 24 + int'(lf[4:0]);
        spawns++;
      end else m_gc = gi;
    end
    m_near = 0;
    for (int i = 0; i < 2; i++)
      if (m_act[i] && m_pos[i] <= 111 && m_pos[i] + 11 >= 72) m_near = 1;
  endtask

  task automatic tick();
    logic [15:0] lf;
    @(negedge clk);
    fresh = 1'b1;
    @(negedge clk);
    fresh = 1'b0;
    lf = lf_m;
    model_tick(lf);
    @(negedge clk);
    chk("obs_near", obs_near, m_near);
  endtask

  task automatic set_gs(logic v);
    @(negedge clk);
    game_status = v;
    if (v && !m_run) begin
      m_run = 1;
      m_act[0] = 0;
      m_act[1] = 0;
      m_gc = 0;
      m_gt = 40;
    end else if (!v) m_run = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Row 388 is the full-width join row of the small cactus (offset 12)
  task automatic check_slots();
    for (int i = 0; i < 2; i++)
      if (m_act[i] && m_pos[i] >= 33) begin
        probe(388, m_pos[i] - 32, 1'b1, "left_edge");
        probe(388, m_pos[i] - 33, 1'b0, "left_out");
        probe(388, m_pos[i] - 20, 1'b0, "small_width");
      end
    flush();
  endtask

  initial begin
    int  n, o;
    bit  found;
    int  fp[2];
    bit  fa[2];

    rst = 1'b1; fresh = 1'b0; game_status = 1'b0; speed = 4'd4;
    row_addr = '0; col_addr = '0;
    m_run = 0; m_act[0] = 0; m_act[1] = 0; m_pos[0] = 0; m_pos[1] = 0;
    m_gc = 0; m_gt = 40; m_near = 0; spawns = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_obs_near", obs_near, 1'b0);
    chk("rst_px", px, 1'b0);

    // First spawn lands on tick 40 at 672, then moves to 668
    set_gs(1'b1);
    for (int t = 1; t <= 41; t++) begin
      tick();
      if (t == 39) begin probe(388, 640, 1'b0, "no_spawn_t39"); flush(); end
      if (t == 40) begin
        probe(388, 640, 1'b1, "spawn672");
        probe(388, 639, 1'b0, "spawn672_left");
        flush();
      end
      if (t == 41) begin
        probe(388, 636, 1'b1, "move668");
        probe(388, 635, 1'b0, "move668_left");
        flush();
      end
    end

    // Sprite rows at position 132 (screen columns 100..111)
    found = 0;
    for (n = 0; n < 300 && !found; n++) begin
      if (m_act[0] && m_pos[0] == 132) found = 1;
      else begin tick(); check_slots(); end
    end
    chk_done("reach_pos132", found);
    for (int c = 98; c <= 113; c++) probe(380, c, small_bit(4, c - 100), "row380");
    for (int c = 98; c <= 113; c++) probe(382, c, small_bit(6, c - 100), "row382");
    for (int c = 102; c <= 109; c++) probe(376, c, small_bit(0, c - 100), "row376");
    for (int c = 102; c <= 109; c++) probe(399, c, small_bit(23, c - 100), "row399");
    for (int c = 103; c <= 108; c++) probe(400, c, 1'b0, "row400");
    probe(375, 105, 1'b0, "row375");
    flush();

    // Both slots busy with gap saturated, then retire the older one from position 3
    found = 0;
    for (n = 0; n < 400 && !found; n++) begin
      if (m_act[0] && m_act[1] && m_gc == m_gt) found = 1;
      else begin tick(); check_slots(); end
    end
    chk_done("both_busy_saturated", found);
    o = (m_pos[0] < m_pos[1]) ? 0 : 1;
    for (n = 0; n < 100 && m_pos[o] != 3; n++) begin
      speed = (m_pos[o] - 3 > 15) ? 4'd15 : 4'(m_pos[o] - 3);
      tick();
      check_slots();
    end
    chk_done("land_pos3", m_pos[o] == 3 && m_act[o]);
    probe(388, 640, 1'b0, "no_spawn_while_busy");
    flush();
    speed = 4'd4;
    tick();
    probe(388, 640, 1'b0, "no_spawn_on_retire_tick");
    flush();
    check_slots();
    tick();
    probe(388, 640, 1'b1, "spawn_after_retire");
    flush();
    check_slots();

    // Stop mid-run: frozen for 10 ticks; restart clears everything
    for (int t = 0; t < 30; t++) begin tick(); check_slots(); end
    set_gs(1'b0);
    for (int t = 0; t < 10; t++) begin tick(); check_slots(); end
    for (int i = 0; i < 2; i++) begin fp[i] = m_pos[i]; fa[i] = m_act[i]; end
    set_gs(1'b1);
    for (int i = 0; i < 2; i++)
      if (fa[i] && fp[i] >= 33) probe(388, fp[i] - 32, 1'b0, "cleared_on_restart");
    probe(388, 640, 1'b0, "cleared_spawn_col");
    flush();
    tick();
    check_slots();

    // Long run with varying speed: 20 spawns, all small, obs_near tracked per tick
    spawns = 0;
    for (n = 0; n < 3000 && spawns < 20; n++) begin
      speed = 4'($urandom_range(2, 12));
      tick();
      check_slots();
    end
    chk_done("twenty_spawns", spawns >= 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 SHALL have parameter SPAWN_X, default 11'd672, meaning slot position loaded at spawn (screen column = position - 32).
REQ-002 SHALL have parameter GAP_MIN, default 6'd24, meaning minimum frames between spawns.
REQ-003 SHALL have ports: clk  in  1  pixel clock, driven from clkdiv[0].
REQ-004 SHALL have: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have: fresh  in  1  frame strobe; a frame tick is its falling edge, sampled in clk.
REQ-006 SHALL have: game_status  in  1  1 = running, 0 = stopped.
REQ-007 SHALL have: speed  in  4  pixels moved per frame tick, the same value the ground scroller uses.
REQ-008 SHALL have: row_addr  in  9 and col_addr  in  10  current VGA pixel.
REQ-009 SHALL have: px  out  1  obstacle pixel, for OR-ing with the ground pixel.
REQ-010 SHALL have: obs_near  out  1  some active obstacle overlaps screen columns 40..79 (dino band).

Function
REQ-011 SHALL detect a tick as fresh_q=1 and fresh=0, with fresh_q registered every clk; slot, gap and obs_near updates SHALL occur on the tick cycle.
REQ-012 SHALL hold two slots, each with active bit, 11-bit position and 1-bit type (0 small 12x24, 1 large 20x40); bottom row 399 (ground top is row 400).
REQ-013 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) every clk, regardless of game_status.
REQ-014 SHALL use states IDLE (game_status=0) and RUN; IDLE->RUN on game_status rising edge; RUN->IDLE on falling edge.
REQ-015 SHALL on IDLE->RUN clear both slots, zero gap_cnt and set gap_target=GAP_MIN+16.
REQ-016 SHALL in IDLE freeze slot positions and gap_cnt; px still renders frozen slots.
REQ-017 SHALL in RUN on each tick: for an active slot with position <= speed, clear the slot; otherwise subtract speed from position.
REQ-018 SHALL in RUN on each tick increment gap_cnt while below gap_target, saturating at gap_target.
REQ-019 SHALL spawn on a tick when gap_cnt==gap_target and a slot was free before this tick's retire: lowest-index free slot, position=SPAWN_X, type=LFSR[5]; gap_cnt:=0; gap_target:=GAP_MIN+LFSR[4:0].
REQ-020 SHALL not use a slot freed by a retire on the same tick; the spawn waits for the next tick.
REQ-021 SHALL when both slots are busy at gap_target hold gap_cnt at target and spawn on the first tick a slot is free.
REQ-022 SHALL register px with 1 clk latency: px=1 iff some active slot's box contains (col_addr, row_addr) and the sprite ROM bit at (row offset, column offset) is 1.
REQ-023 SHALL compute box tests with 11-bit unsigned arithmetic on position and col_addr+32, avoiding underflow.
REQ-024 SHALL register obs_near at each tick from the post-update slot state.

Reset
REQ-025 SHALL on rst: slots inactive; gap_cnt=0; gap_target=GAP_MIN+16; state IDLE; LFSR=16'hACE1; fresh_q=0; px=0; obs_near=0.
REQ-026 SHALL give rst priority over the tick and game_status edges in the same cycle.

Configuration
REQ-027 SHALL with OBSTACLE_LARGE_EN defined choose spawn type from LFSR[5]; without it, every spawn is type 0 and large-sprite ROM rows are not built.

Structure
REQ-028 SHALL place sprite dimensions, SPAWN offset 32, dino band 40..79, LFSR seed and taps in shared package game_pkg.
REQ-029 SHALL implement sprite bitmaps in sub-module cactus_rom: inputs type and 6-bit row, output 20-bit row, combinational.

Verification
REQ-030 SHALL: rst, game_status 0->1, 40 ticks, speed=4 -> slot0 spawns on tick 40 at 672, then 668 on tick 41.
REQ-031 SHALL: slot at position 3, speed=4, tick -> slot cleared; a pending spawn lands on the following tick, not the same one.
REQ-032 SHALL: both slots busy, gap reached -> no spawn; on the tick slot1 retires, spawn into slot1 one tick later.
REQ-033 SHALL: small cactus at position 132, row 380, col 100..111 -> px follows ROM row with 1 clk delay; row 400 -> px=0.
REQ-034 SHALL: game_status 1->0 mid-run -> positions frozen over 10 ticks; 0->1 -> slots cleared, px=0.
REQ-035 SHALL: without OBSTACLE_LARGE_EN, 20 spawns -> all type 0; obs_near=1 exactly while a box overlaps cols 40..79.
